// File: rtl/txn_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready transaction port among N_REQ requesters.
// An owner keeps the port until a beat with last transfers or MAX_HOLD beats have transferred.
module txn_rr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [PTR_W-1:0]   owner_idx;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand_idx;
  logic               pick_found;
  int unsigned        cand;
  logic [CNT_W-1:0]   beat_cnt_inc;
  logic               any_req;
  logic               xfer;
  logic               release_now;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= PTR_W'(N_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
  end

  // Rotating scan starting just after the last owner; modulo keeps non-power-of-two N_REQ in range.
  always_comb begin
    pick_idx   = ptr_q;
    pick_found = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand     = (32'(ptr_q) + off) % N_REQ;
      cand_idx = PTR_W'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_idx   = cand_idx;
        pick_found = 1'b1;
      end
    end
  end

  assign any_req      = |req_valid;
  assign beat_cnt_inc = beat_cnt_q + 1'b1;
  assign xfer         = (state_q == GRANT) && out_valid && out_ready;
  assign release_now  = xfer && (out_last || (beat_cnt_inc == CNT_W'(MAX_HOLD)));

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_d[i] = (pick_idx == PTR_W'(i));
          end
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d      = owner_idx;
          grant_d    = '0;
          beat_cnt_d = '0;
          state_d    = IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output logic: owner's stream is muxed through using the registered one-hot grant
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    if (state_q == GRANT) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant_q[i]) begin
          out_valid = req_valid[i];
          out_data  = req_data[i*DATA_W +: DATA_W];
          out_last  = req_last[i];
        end
      end
      req_ready = grant_q & {N_REQ{out_ready}};
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == GRANT);

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

endmodule
